// File: rtl/key_codes_pkg.sv
// Key codes from the PS/2 decoder and the entry FSM state encodings
// shared by the keypad sequencer and its users.
package key_codes_pkg;

  localparam int KEY_DIGIT_MAX = 9;
  localparam int KEY_OP_LO     = 20;
  localparam int KEY_OP_HI     = 23;
  localparam int KEY_ENTER     = 26;
  localparam int KEY_RUN       = 27;
  localparam int KEY_CLEAR     = 28;

  // Encodings are shown on the 7-seg debug display, so they are fixed.
  typedef enum logic [2:0] {
    S_OP1   = 3'd0,
    S_OP2   = 3'd1,
    S_ASM   = 3'd2,
    S_ARMED = 3'd3,
    S_RUN   = 3'd4
  } entry_state_e;

endpackage

// File: rtl/key_entry_sequencer_if.sv
// Key strobe bus from the PS/2 key decoder (master) to the sequencer (slave).
interface key_entry_sequencer_if #(
  parameter int KEY_WIDTH = 8
);

  logic [KEY_WIDTH-1:0] key_code;
  logic                 key_valid;

  modport master (output key_code, output key_valid);
  modport slave  (input  key_code, input  key_valid);

endinterface

// File: rtl/decimal_accumulator.sv
// Builds a saturating decimal operand one digit per load; clear and load
// together start a fresh operand with that digit.
module decimal_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  RESET,
  input  logic                  clear,
  input  logic                  load,
  input  logic [3:0]            digit,
  output logic [DATA_WIDTH-1:0] value,
  output logic [2:0]            count,
  output logic                  saturated
);

  localparam int SUM_W = DATA_WIDTH + 4;
  localparam logic [SUM_W-1:0] MAX_VALUE = {4'd0, {DATA_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] base_value;
  logic [2:0]            base_count;
  logic [SUM_W-1:0]      wide;
  logic [SUM_W-1:0]      next_sum;
  logic                  take;

  // acc*10 as two shifts; four extra bits hold the worst case before saturation.
  always_comb begin
    base_value = clear ? '0 : value;
    base_count = clear ? 3'd0 : count;
    take       = load && (base_count < 3'(MAX_DIGITS));
    wide       = SUM_W'(base_value);
    next_sum   = (wide << 3) + (wide << 1) + SUM_W'(digit);
    saturated  = take && (next_sum > MAX_VALUE);
  end

  always_ff @(posedge clock) begin
    if (RESET) begin
      value <= '0;
      count <= '0;
    end else if (take) begin
      value <= saturated ? {DATA_WIDTH{1'b1}} : next_sum[DATA_WIDTH-1:0];
      count <= base_count + 3'd1;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end
  end

endmodule

// File: rtl/key_entry_sequencer.sv
// Keypad command sequencer: collects two decimal operands and an operator,
// then sequences assembler enable, program run and soft reset.
module key_entry_sequencer
  import key_codes_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          KEY_WIDTH      = 8,
  parameter int          MAX_DIGITS     = 2,
  parameter int          ASM_HOLD       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                    clock,
  input  logic                    RESET,
  key_entry_sequencer_if.slave    keys,
  input  logic                    cpu_done,
  output logic [DATA_WIDTH-1:0]   operand1,
  output logic [DATA_WIDTH-1:0]   operand2,
  output logic [KEY_WIDTH-1:0]    operator_code,
  output logic [2:0]              digit_count,
  output logic                    assembler_en,
  output logic                    cu_enable,
  output logic                    soft_reset,
  output logic [2:0]              entry_state,
  output logic                    overflow,
  output logic                    timeout
);

  localparam int HOLD_W = (ASM_HOLD > 1) ? $clog2(ASM_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ASM_HOLD - 1);
  localparam logic [31:0] IDLE_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  entry_state_e          state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [31:0]           idle_cnt;
  logic [DATA_WIDTH-1:0] acc_value;
  logic key_digit, key_op, key_enter, key_run, key_clear, key_known;
  logic idle_run, timeout_fire, acc_clear, acc_load, acc_sat;

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    key_digit = keys.key_valid && (keys.key_code <= KEY_WIDTH'(KEY_DIGIT_MAX));
    key_op    = keys.key_valid && (keys.key_code >= KEY_WIDTH'(KEY_OP_LO))
                               && (keys.key_code <= KEY_WIDTH'(KEY_OP_HI));
    key_enter = keys.key_valid && (keys.key_code == KEY_WIDTH'(KEY_ENTER));
    key_run   = keys.key_valid && (keys.key_code == KEY_WIDTH'(KEY_RUN));
    key_clear = keys.key_valid && (keys.key_code == KEY_WIDTH'(KEY_CLEAR));
    key_known = key_digit || key_op || key_enter || key_run || key_clear;

    // A pending key always beats an expiring idle counter.
    idle_run     = ((state == S_OP1) && (digit_count != 3'd0)) || (state == S_OP2);
    timeout_fire = (TIMEOUT_CYCLES != 0) && idle_run && !key_known && (idle_cnt == IDLE_LAST);

    acc_load  = key_digit && ((state == S_OP1) || (state == S_OP2) || (state == S_ARMED));
    acc_clear = key_clear || timeout_fire
             || ((state == S_OP1)   && key_op)
             || ((state == S_ARMED) && key_digit)
             || ((state == S_RUN)   && cpu_done);
  end

  decimal_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clock     (clock),
    .RESET     (RESET),
    .clear     (acc_clear),
    .load      (acc_load),
    .digit     (keys.key_code[3:0]),
    .value     (acc_value),
    .count     (digit_count),
    .saturated (acc_sat)
  );

  assign entry_state = state;

  // NOTE: RESET is synchronous, so it lives inside the clocked block; all state uses <=.
  always_ff @(posedge clock) begin
    if (RESET || key_clear) begin
      state         <= S_OP1;
      operand1      <= '0;
      operand2      <= '0;
      operator_code <= '0;
      assembler_en  <= 1'b0;
      cu_enable     <= 1'b0;
      overflow      <= 1'b0;
      timeout       <= 1'b0;
      soft_reset    <= !RESET;
      hold_cnt      <= '0;
      idle_cnt      <= '0;
    end else begin
      soft_reset <= 1'b0;
      if (key_known) begin
        idle_cnt <= '0;
        timeout  <= 1'b0;
      end else if (idle_run) begin
        idle_cnt <= idle_cnt + 32'd1;
      end else begin
        idle_cnt <= '0;
      end

      if (timeout_fire) begin
        state         <= S_OP1;
        operand1      <= '0;
        operand2      <= '0;
        operator_code <= '0;
        timeout       <= 1'b1;
      end else begin
        case (state)
          S_OP1: if (key_op) begin
            operand1      <= acc_value;
            operator_code <= keys.key_code;
            state         <= S_OP2;
          end
          S_OP2: if (key_op && (digit_count == 3'd0)) begin
            operator_code <= keys.key_code;
          end else if (key_enter) begin
            operand2     <= acc_value;
            assembler_en <= 1'b1;
            hold_cnt     <= HOLD_LAST;
            state        <= S_ASM;
          end
          // The assembler_en falling edge is where downstream latches the program.
          S_ASM: if (hold_cnt == '0) begin
            assembler_en <= 1'b0;
            state        <= S_ARMED;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
          S_ARMED: if (key_run) begin
            cu_enable <= 1'b1;
            state     <= S_RUN;
          end else if (key_digit) begin
            operand1      <= '0;
            operand2      <= '0;
            operator_code <= '0;
            overflow      <= 1'b0;
            state         <= S_OP1;
          end
          S_RUN: if (cpu_done) begin
            cu_enable <= 1'b0;
            state     <= S_OP1;
          end
          default: state <= S_OP1;
        endcase
      end

      if (acc_sat) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Scoreboard bench: stimulus queues the expected output snapshot for each key
// or probe; a monitor compares it one edge later.
`timescale 1ns/1ps
module tb_key_entry_sequencer;
  import key_codes_pkg::*;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [7:0] op1, op2, opc;
    logic [2:0] dc;
    logic       asm_en, cu_en, srst, ovf, tmo;
  } exp_t;

  logic clock = 1'b0;
  logic RESET = 1'b1;
  logic cpu_done = 1'b0;
  logic cpu_done_b = 1'b0;
  logic probe = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] operand1, operand2, operator_code;
  logic [2:0] digit_count, entry_state;
  logic       assembler_en, cu_enable, soft_reset, overflow, timeout;
  logic [7:0] operand1_b, operand2_b, operator_code_b;
  logic [2:0] digit_count_b, entry_state_b;
  logic       assembler_en_b, cu_enable_b, soft_reset_b, overflow_b, timeout_b;

  key_entry_sequencer_if #(.KEY_WIDTH(8)) kif ();
  key_entry_sequencer_if #(.KEY_WIDTH(8)) kif_b ();

  key_entry_sequencer #(.DATA_WIDTH(8), .KEY_WIDTH(8), .MAX_DIGITS(2),
                        .ASM_HOLD(16), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .RESET(RESET), .keys(kif), .cpu_done(cpu_done),
    .operand1(operand1), .operand2(operand2), .operator_code(operator_code),
    .digit_count(digit_count), .assembler_en(assembler_en), .cu_enable(cu_enable),
    .soft_reset(soft_reset), .entry_state(entry_state), .overflow(overflow),
    .timeout(timeout)
  );

  key_entry_sequencer #(.DATA_WIDTH(8), .KEY_WIDTH(8), .MAX_DIGITS(3),
                        .ASM_HOLD(16), .TIMEOUT_CYCLES(100)) dut_b (
    .clock(clock), .RESET(RESET), .keys(kif_b), .cpu_done(cpu_done_b),
    .operand1(operand1_b), .operand2(operand2_b), .operator_code(operator_code_b),
    .digit_count(digit_count_b), .assembler_en(assembler_en_b), .cu_enable(cu_enable_b),
    .soft_reset(soft_reset_b), .entry_state(entry_state_b), .overflow(overflow_b),
    .timeout(timeout_b)
  );

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_expect();
    e.st = 3'd0; e.op1 = 8'd0; e.op2 = 8'd0; e.opc = 8'd0; e.dc = 3'd0;
    e.asm_en = 1'b0; e.cu_en = 1'b0; e.srst = 1'b0; e.ovf = 1'b0; e.tmo = 1'b0;
  endtask

  // Called on a negedge; the key is sampled on the following posedge.
  task automatic send_key(input string tag, input int k);
    kif.key_code  = 8'(k);
    kif.key_valid = 1'b1;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clock);
    kif.key_valid = 1'b0;
  endtask

  task automatic probe_check(input string tag);
    e.tag = tag;
    sb_q.push_back(e);
    probe = 1'b1;
    @(negedge clock);
    probe = 1'b0;
  endtask

  task automatic send_key_b(input int k);
    kif_b.key_code  = 8'(k);
    kif_b.key_valid = 1'b1;
    @(negedge clock);
    kif_b.key_valid = 1'b0;
  endtask

  task automatic wait_asm_low(output int n);
    n = 0;
    while (assembler_en === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  // Monitor: every key strobe or probe yields one response after the next edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      if (kif.key_valid === 1'b1 || probe === 1'b1) begin
        @(negedge clock);
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          x = sb_q.pop_front();
          check({x.tag, ".state"},         32'(entry_state),   32'(x.st));
          check({x.tag, ".operand1"},      32'(operand1),      32'(x.op1));
          check({x.tag, ".operand2"},      32'(operand2),      32'(x.op2));
          check({x.tag, ".operator_code"}, 32'(operator_code), 32'(x.opc));
          check({x.tag, ".digit_count"},   32'(digit_count),   32'(x.dc));
          check({x.tag, ".assembler_en"},  32'(assembler_en),  32'(x.asm_en));
          check({x.tag, ".cu_enable"},     32'(cu_enable),     32'(x.cu_en));
          check({x.tag, ".soft_reset"},    32'(soft_reset),    32'(x.srst));
          check({x.tag, ".overflow"},      32'(overflow),      32'(x.ovf));
          check({x.tag, ".timeout"},       32'(timeout),       32'(x.tmo));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    kif.key_valid = 1'b0;   kif.key_code = 8'd0;
    kif_b.key_valid = 1'b0; kif_b.key_code = 8'd0;
    repeat (3) @(negedge clock);
    RESET = 1'b0;
    clear_expect();
    probe_check("reset");

    // Three-digit instance: 9,9,9 saturates at 255.
    send_key_b(9); send_key_b(9); send_key_b(9);
    check("b_digit_count", 32'(digit_count_b), 32'd3);
    check("b_overflow_set", 32'(overflow_b), 32'd1);
    send_key_b(KEY_OP_LO);
    check("b_operand1_sat", 32'(operand1_b), 32'd255);
    check("b_overflow_held", 32'(overflow_b), 32'd1);

    // 42 + 17 ENTER
    e.dc = 3'd1; send_key("d4", 4);
    e.dc = 3'd2; send_key("d2", 2);
    e.op1 = 8'd42; e.opc = 8'd20; e.st = 3'd1; e.dc = 3'd0; send_key("op_plus", 20);
    e.dc = 3'd1; send_key("d1", 1);
    e.dc = 3'd2; send_key("d7", 7);
    e.op2 = 8'd17; e.asm_en = 1'b1; e.st = 3'd2; send_key("enter", KEY_ENTER);
    wait_asm_low(n);
    check("asm_hold_cycles", 32'(n), 32'd16);
    e.asm_en = 1'b0; e.st = 3'd3; probe_check("armed");
    send_key("undefined_key", 'h55);
    e.cu_en = 1'b1; e.st = 3'd4; send_key("run", KEY_RUN);
    send_key("digit_in_run", 5);
    repeat (8) @(negedge clock);
    cpu_done = 1'b1;
    e.cu_en = 1'b0; e.st = 3'd0; e.dc = 3'd0; probe_check("cpu_done");
    cpu_done = 1'b0;

    // Digit limit, operator replace/ignore, CLEAR inside S_ASM
    e.dc = 3'd1; send_key("d9_a", 9);
    e.dc = 3'd2; send_key("d9_b", 9);
    send_key("d9_ignored", 9);
    e.op1 = 8'd99; e.opc = 8'd20; e.st = 3'd1; e.dc = 3'd0; send_key("op_after_99", 20);
    e.opc = 8'd21; send_key("op_replace", 21);
    e.dc = 3'd1; send_key("d1_op2", 1);
    send_key("op_ignored", 22);
    e.op2 = 8'd1; e.asm_en = 1'b1; e.st = 3'd2; send_key("enter2", KEY_ENTER);
    send_key("enter_in_asm", KEY_ENTER);
    clear_expect(); e.srst = 1'b1; send_key("clear_in_asm", KEY_CLEAR);
    e.srst = 1'b0; probe_check("after_clear");

    // 5 - 3 then idle until the entry is discarded
    e.dc = 3'd1; send_key("d5", 5);
    e.op1 = 8'd5; e.opc = 8'd21; e.st = 3'd1; e.dc = 3'd0; send_key("op_minus", 21);
    e.dc = 3'd1; send_key("d3", 3);
    n = 0;
    while (timeout !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("timeout_window", 32'(n >= 99 && n <= 101), 32'd1);
    clear_expect(); e.tmo = 1'b1; probe_check("timeout");
    e.tmo = 1'b0; e.dc = 3'd1; send_key("key_after_timeout", 7);

    // cpu_done already high when RUN is accepted
    e.op1 = 8'd7; e.opc = 8'd20; e.st = 3'd1; e.dc = 3'd0; send_key("op_plus2", 20);
    e.dc = 3'd1; send_key("d2_op2", 2);
    e.op2 = 8'd2; e.asm_en = 1'b1; e.st = 3'd2; send_key("enter3", KEY_ENTER);
    wait_asm_low(n);
    check("asm_hold_cycles2", 32'(n), 32'd16);
    e.asm_en = 1'b0; e.st = 3'd3; probe_check("armed2");
    cpu_done = 1'b1;
    e.cu_en = 1'b1; e.st = 3'd4; send_key("run_done_high", KEY_RUN);
    e.cu_en = 1'b0; e.st = 3'd0; e.dc = 3'd0; probe_check("done_on_entry");
    cpu_done = 1'b0;

    // RESET while the program runs
    e.op1 = 8'd0; e.opc = 8'd20; e.st = 3'd1; send_key("op_empty", 20);
    e.dc = 3'd1; send_key("d4_op2", 4);
    e.op2 = 8'd4; e.asm_en = 1'b1; e.st = 3'd2; send_key("enter4", KEY_ENTER);
    wait_asm_low(n);
    e.asm_en = 1'b0; e.st = 3'd3; probe_check("armed3");
    e.cu_en = 1'b1; e.st = 3'd4; send_key("run2", KEY_RUN);
    RESET = 1'b1;
    clear_expect(); probe_check("reset_in_run");
    RESET = 1'b0;

    repeat (2) @(negedge clock);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
